// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register followed by the execute-stage operand selection
//   that feeds the alu. Decoded operands and control are captured every cycle
//   unless the hazard unit stalls (hold) or flushes (bubble) the stage.
//   Forwarding muxes pick the alu operands. The branch decision returned by
//   the alu in the same cycle resolves PCSrcE. PCTargetE is always PCE + ImmExtE;
//   JALR targets are produced outside this block.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   StallE, FlushE        hazard-unit hold / bubble requests (flush wins)
//   RD1D, RD2D            register-file read data from decode
//   PCD, ImmExtD          decode PC and extended immediate
//   Rs1D, Rs2D, RdD       source / destination register indices
//   ALUControlD, ALUSrcD  alu opcode and SrcB select (1 = immediate)
//   RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD   decoded control
//   ForwardAE, ForwardBE  00/11 register, 01 ResultW, 10 ALUResultM
//   ResultW, ALUResultM   forwarding sources from later stages
//   ALU_branch            branch condition from the alu (same cycle)
//   SrcAE, SrcBE, ALUControlE   alu operands and opcode
//   WriteDataE            forwarded RD2 (store data)
//   PCTargetE, PCPlus4E   PCE + ImmExtE and PCE + 4, both wrap modulo 2^XLEN
//   PCSrcE                (BranchE & ALU_branch) | JumpE
//   Rs1E, Rs2E, RdE       registered indices for the hazard unit
//   RegWriteE, MemWriteE, ResultSrcE   registered control for later stages
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [RW-1:0]   Rs1D,
  input  logic [RW-1:0]   Rs2D,
  input  logic [RW-1:0]   RdD,
  input  logic [3:0]      ALUControlD,
  input  logic            ALUSrcD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic [1:0]      ResultSrcD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic            ALU_branch,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            PCSrcE,
  output logic [RW-1:0]   Rs1E,
  output logic [RW-1:0]   Rs2E,
  output logic [RW-1:0]   RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic [1:0]      ResultSrcE
);

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [RW-1:0]   ZERO_R = {RW{1'b0}};
  localparam logic [XLEN-1:0] FOUR_X = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] rd1_r, rd2_r, pc_r, imm_r;
  logic [RW-1:0]   rs1_r, rs2_r, rd_r;
  logic [3:0]      alu_ctrl_r;
  logic            alu_src_r, reg_write_r, mem_write_r, branch_r, jump_r;
  logic [1:0]      result_src_r;

  logic [XLEN-1:0] src_a_s, write_data_s, src_b_s;

  // ID/EX register: reset, then flush (bubble = add, no side effects), then stall hold.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      rd1_r        <= ZERO_X;
      rd2_r        <= ZERO_X;
      pc_r         <= ZERO_X;
      imm_r        <= ZERO_X;
      rs1_r        <= ZERO_R;
      rs2_r        <= ZERO_R;
      rd_r         <= ZERO_R;
      alu_ctrl_r   <= 4'b0000;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      branch_r     <= 1'b0;
      jump_r       <= 1'b0;
      result_src_r <= 2'b00;
    end else if (!StallE) begin
      rd1_r        <= RD1D;
      rd2_r        <= RD2D;
      pc_r         <= PCD;
      imm_r        <= ImmExtD;
      rs1_r        <= Rs1D;
      rs2_r        <= Rs2D;
      rd_r         <= RdD;
      alu_ctrl_r   <= ALUControlD;
      alu_src_r    <= ALUSrcD;
      reg_write_r  <= RegWriteD;
      mem_write_r  <= MemWriteD;
      branch_r     <= BranchD;
      jump_r       <= JumpD;
      result_src_r <= ResultSrcD;
    end
  end

  // SrcA forwarding mux; x0 always reads as zero, even if a forward is requested.
  always_comb begin
    src_a_s = rd1_r;
    if (rs1_r == ZERO_R) begin
      src_a_s = ZERO_X;
    end else begin
      case (ForwardAE)
        2'b01:   src_a_s = ResultW;
        2'b10:   src_a_s = ALUResultM;
        default: src_a_s = rd1_r;
      endcase
    end
  end

  // Store-data forwarding mux, same x0 rule as SrcA.
  always_comb begin
    write_data_s = rd2_r;
    if (rs2_r == ZERO_R) begin
      write_data_s = ZERO_X;
    end else begin
      case (ForwardBE)
        2'b01:   write_data_s = ResultW;
        2'b10:   write_data_s = ALUResultM;
        default: write_data_s = rd2_r;
      endcase
    end
  end

  // SrcB picks the immediate or the forwarded register value.
  always_comb begin
    src_b_s = write_data_s;
    if (alu_src_r) begin
      src_b_s = imm_r;
    end else begin
      src_b_s = write_data_s;
    end
  end

  assign SrcAE       = src_a_s;
  assign SrcBE       = src_b_s;
  assign WriteDataE  = write_data_s;
  assign ALUControlE = alu_ctrl_r;
  // Both adders drop the carry out, so targets wrap around the address space.
  assign PCTargetE   = pc_r + imm_r;
  assign PCPlus4E    = pc_r + FOUR_X;
  assign PCSrcE      = (branch_r & ALU_branch) | jump_r;
  assign Rs1E        = rs1_r;
  assign Rs2E        = rs2_r;
  assign RdE         = rd_r;
  assign RegWriteE   = reg_write_r;
  assign MemWriteE   = mem_write_r;
  assign ResultSrcE  = result_src_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
//   Table-driven bench for id_ex_operand_stage. Each record holds the inputs
//   driven before a rising edge and the outputs expected just after it.
//   Reset, stall and flush sequences are built inline from the same record type.
module tb_id_ex_operand_stage;

  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] rd1, rd2, pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluc;
    logic        alusrc, regw, memw, br, jmp;
    logic [1:0]  rsrc, fa, fb;
    logic [31:0] resw, alum;
    logic        albr;
    logic [31:0] e_srca, e_srcb, e_wd, e_pct, e_pcp4;
    logic        e_pcsrc;
    logic [3:0]  e_aluc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_regw, e_memw;
    logic [1:0]  e_rsrc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, ResultW, ALUResultM;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [3:0]  ALUControlD;
  logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ALU_branch;
  logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
  logic [3:0]  ALUControlE;
  logic        PCSrcE, RegWriteE, MemWriteE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  ResultSrcE;

  int tests = 0;
  int fails = 0;

  id_ex_operand_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ResultSrcD(ResultSrcD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ALUResultM(ALUResultM), .ALU_branch(ALU_branch),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E), .PCSrcE(PCSrcE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; StallE = v.stall; FlushE = v.flush;
    RD1D = v.rd1; RD2D = v.rd2; PCD = v.pc; ImmExtD = v.imm;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    ALUControlD = v.aluc; ALUSrcD = v.alusrc;
    RegWriteD = v.regw; MemWriteD = v.memw; BranchD = v.br; JumpD = v.jmp;
    ResultSrcD = v.rsrc; ForwardAE = v.fa; ForwardBE = v.fb;
    ResultW = v.resw; ALUResultM = v.alum; ALU_branch = v.albr;
  endtask

  // Drive one record, clock it in, then compare every output 1 ns after the edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, " SrcAE"},       SrcAE,               v.e_srca);
    chk({tag, " SrcBE"},       SrcBE,               v.e_srcb);
    chk({tag, " WriteDataE"},  WriteDataE,          v.e_wd);
    chk({tag, " PCTargetE"},   PCTargetE,           v.e_pct);
    chk({tag, " PCPlus4E"},    PCPlus4E,            v.e_pcp4);
    chk({tag, " PCSrcE"},      32'(PCSrcE),         32'(v.e_pcsrc));
    chk({tag, " ALUControlE"}, 32'(ALUControlE),    32'(v.e_aluc));
    chk({tag, " Rs1E"},        32'(Rs1E),           32'(v.e_rs1));
    chk({tag, " Rs2E"},        32'(Rs2E),           32'(v.e_rs2));
    chk({tag, " RdE"},         32'(RdE),            32'(v.e_rd));
    chk({tag, " RegWriteE"},   32'(RegWriteE),      32'(v.e_regw));
    chk({tag, " MemWriteE"},   32'(MemWriteE),      32'(v.e_memw));
    chk({tag, " ResultSrcE"},  32'(ResultSrcE),     32'(v.e_rsrc));
  endtask

  vec_t tbl [10];
  vec_t v;

  initial begin
    // fields: rst stall flush | rd1 rd2 pc imm | rs1 rs2 rd | aluc | alusrc regw memw br jmp | rsrc fa fb | resw alum albr
    //         || srca srcb wd pct pcp4 | pcsrc aluc | rs1 rs2 rd | regw memw rsrc
    // forwarding A=10 (ALUResultM), B=00
    tbl[0] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h200,32'h10, 5'd3,5'd4,5'd7, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd0, 32'h99,32'h77,1'b0,
               32'h77,32'h8,32'h8,32'h210,32'h204, 1'b0,4'h0, 5'd3,5'd4,5'd7, 1'b1,1'b0,2'd0};
    // forwarding A=01, B=01 (ResultW)
    tbl[1] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h200,32'h10, 5'd3,5'd4,5'd7, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd1, 32'h99,32'h77,1'b0,
               32'h99,32'h99,32'h99,32'h210,32'h204, 1'b0,4'h0, 5'd3,5'd4,5'd7, 1'b1,1'b0,2'd0};
    // forwarding 11 behaves like 00
    tbl[2] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h200,32'h10, 5'd3,5'd4,5'd7, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd3,2'd3, 32'h99,32'h77,1'b0,
               32'h5,32'h8,32'h8,32'h210,32'h204, 1'b0,4'h0, 5'd3,5'd4,5'd7, 1'b1,1'b0,2'd0};
    // x0 sources: forwarding requested but operands stay zero
    tbl[3] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h200,32'h10, 5'd0,5'd0,5'd7, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd1, 32'h99,32'h77,1'b0,
               32'h0,32'h0,32'h0,32'h210,32'h204, 1'b0,4'h0, 5'd0,5'd0,5'd7, 1'b1,1'b0,2'd0};
    // ALUSrc=1: SrcB = immediate, WriteData = RD2
    tbl[4] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h200,32'hFFFFFFF0, 5'd3,5'd4,5'd0, 4'h0, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'd1,2'd0,2'd0, 32'h99,32'h77,1'b0,
               32'h5,32'hFFFFFFF0,32'h8,32'h1F0,32'h204, 1'b0,4'h0, 5'd3,5'd4,5'd0, 1'b0,1'b1,2'd1};
    // branch taken
    tbl[5] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h100,32'h20, 5'd3,5'd4,5'd0, 4'hC, 1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd0,2'd0, 32'h99,32'h77,1'b1,
               32'h5,32'h8,32'h8,32'h120,32'h104, 1'b1,4'hC, 5'd3,5'd4,5'd0, 1'b0,1'b0,2'd0};
    // branch not taken
    tbl[6] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h100,32'h20, 5'd3,5'd4,5'd0, 4'hC, 1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd0,2'd0, 32'h99,32'h77,1'b0,
               32'h5,32'h8,32'h8,32'h120,32'h104, 1'b0,4'hC, 5'd3,5'd4,5'd0, 1'b0,1'b0,2'd0};
    // jump: PCSrcE regardless of ALU_branch
    tbl[7] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'h100,32'h20, 5'd3,5'd4,5'd1, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b1, 2'd2,2'd0,2'd0, 32'h99,32'h77,1'b0,
               32'h5,32'h8,32'h8,32'h120,32'h104, 1'b1,4'h0, 5'd3,5'd4,5'd1, 1'b1,1'b0,2'd2};
    // address wrap
    tbl[8] = '{1'b0,1'b0,1'b0, 32'h5,32'h8,32'hFFFFFFFC,32'h8, 5'd3,5'd4,5'd2, 4'h0, 1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 32'h99,32'h77,1'b1,
               32'h5,32'h8,32'h8,32'h4,32'h0, 1'b0,4'h0, 5'd3,5'd4,5'd2, 1'b1,1'b0,2'd0};
    // not a branch: ALU_branch alone must not redirect
    tbl[9] = '{1'b0,1'b0,1'b0, 32'hA5A5A5A5,32'h5A5A5A5A,32'h1000,32'h4, 5'd31,5'd30,5'd29, 4'h9, 1'b0,1'b1,1'b1,1'b0,1'b0, 2'd3,2'd0,2'd2, 32'h99,32'h77,1'b1,
               32'hA5A5A5A5,32'h77,32'h77,32'h1004,32'h1004, 1'b0,4'h9, 5'd31,5'd30,5'd29, 1'b1,1'b1,2'd3};

    // Reset: two cycles with random D-side inputs; forwarding 00, no branch taken.
    for (int i = 0; i < 2; i++) begin
      v = tbl[9];
      v.rst = 1'b1;
      v.rd1 = $urandom; v.rd2 = $urandom; v.pc = $urandom; v.imm = $urandom;
      v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
      v.aluc = 4'($urandom); v.regw = 1'b1; v.memw = 1'b1; v.br = 1'b1; v.jmp = 1'b1;
      v.fa = 2'd0; v.fb = 2'd0; v.albr = 1'b1;
      v.e_srca = 32'h0; v.e_srcb = 32'h0; v.e_wd = 32'h0; v.e_pct = 32'h0; v.e_pcp4 = 32'h4;
      v.e_pcsrc = 1'b0; v.e_aluc = 4'h0; v.e_rs1 = 5'd0; v.e_rs2 = 5'd0; v.e_rd = 5'd0;
      v.e_regw = 1'b0; v.e_memw = 1'b0; v.e_rsrc = 2'd0;
      apply(v, $sformatf("reset%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Stall/flush: load a taken branch at PC 0x40.
    v = tbl[5];
    v.pc = 32'h40; v.regw = 1'b1; v.rd = 5'd6; v.e_rd = 5'd6; v.e_regw = 1'b1;
    v.e_pct = 32'h60; v.e_pcp4 = 32'h44;
    apply(v, "load40");
    // Stall with new decode data: everything holds and the branch re-asserts.
    v.stall = 1'b1;
    v.pc = 32'h44; v.rd1 = 32'h1234; v.rd2 = 32'h4321; v.rd = 5'd9; v.regw = 1'b0;
    v.aluc = 4'h3; v.br = 1'b0;
    apply(v, "stall");
    apply(v, "stall2");
    // Stall and flush together: bubble wins.
    v.flush = 1'b1; v.regw = 1'b1; v.br = 1'b1; v.jmp = 1'b1; v.albr = 1'b1;
    v.e_srca = 32'h0; v.e_srcb = 32'h0; v.e_wd = 32'h0; v.e_pct = 32'h0; v.e_pcp4 = 32'h4;
    v.e_pcsrc = 1'b0; v.e_aluc = 4'h0; v.e_rs1 = 5'd0; v.e_rs2 = 5'd0; v.e_rd = 5'd0;
    v.e_regw = 1'b0; v.e_memw = 1'b0; v.e_rsrc = 2'd0;
    apply(v, "stallflush");
    // Normal load after the bubble, then flush alone.
    apply(tbl[7], "reload");
    v.stall = 1'b0;
    apply(v, "flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
